// File: rtl/hs_sender_pkg.sv
// Shared state encoding and width helper for the send/data/ack handshake initiator.
package hs_sender_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    REL  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/hs_shift_reg.sv
// Parallel-load, serial-out register; the output end is picked by MSB_FIRST.
module hs_shift_reg
  import hs_sender_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= MSB_FIRST ? (sr << 1) : (sr >> 1);
    end
  end

  assign sout = MSB_FIRST ? sr[WIDTH-1] : sr[0];

endmodule

// File: rtl/hs_sender.sv
// Four-phase send/ack initiator: serialises one WIDTH-bit word, one bit per full handshake,
// with a per-phase ack timeout that aborts to a sticky err flag.
module hs_sender
  import hs_sender_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic             send,
  output logic             data,
  input  logic             ack
);

  localparam int unsigned CW = clog2_min1(WIDTH);
  localparam int unsigned TW = clog2_min1(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d, tmr_inc;
  logic            send_q, send_d;
  logic            err_q, err_d;
  logic            load, shift, timeout_hit;

  hs_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_sr (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .shift(shift),
    .din  (din),
    .sout (data)
  );

  assign ready = (state_q == IDLE) & ~ack;
  assign done  = (state_q == DONE);
  assign send  = send_q;
  assign err   = err_q;

  // Timer saturates so a disabled timeout (TIMEOUT=0) can wait forever without wrapping.
  assign tmr_inc     = (tmr_q == '1) ? tmr_q : tmr_q + 1'b1;
  assign timeout_hit = (TIMEOUT != 0) && (tmr_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    send_d  = send_q;
    err_d   = err_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && ready) begin
          load    = 1'b1;
          cnt_d   = '0;
          tmr_d   = '0;
          err_d   = 1'b0;
          send_d  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack) begin
          send_d  = 1'b0;
          tmr_d   = '0;
          state_d = REL;
        end else if (timeout_hit) begin
          send_d  = 1'b0;
          err_d   = 1'b1;
          tmr_d   = '0;
          state_d = ERR;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      REL: begin
        if (!ack) begin
          tmr_d = '0;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = DONE;
          end else begin
            shift   = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            send_d  = 1'b1;
            state_d = REQ;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          tmr_d   = '0;
          state_d = ERR;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      DONE: state_d = IDLE;
      ERR: begin
        send_d  = 1'b0;
        err_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      send_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      send_q  <= send_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_hs_sender.sv
// Bench for hs_sender: LSB-first and MSB-first instances, each driven by a two-stage responder,
// checked every cycle against a transfer-timing model plus directed literal checks.
module tb_hs_sender;

  localparam int W  = 8;
  localparam int TO = 16;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         start     = 1'b0;
  logic [W-1:0] din       = '0;
  logic         force_ack = 1'b0;
  logic         resp_en   = 1'b1;

  logic send_l, data_l, ready_l, done_l, err_l, ack_l;
  logic send_m, data_m, ready_m, done_m, err_m, ack_m;
  logic r1_l = 1'b0, ra_l = 1'b0, r1_m = 1'b0, ra_m = 1'b0;
  logic [W-1:0] cap_l = '0, cap_m = '0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  // transfer model: cycles since the accepting edge and the kind of transfer
  logic         active = 1'b0, noack = 1'b0, m_err = 1'b0;
  int           t       = 0;
  int           acc_cnt = 0;
  logic [W-1:0] word    = '0;

  always #5 clk = ~clk;

  hs_sender #(.WIDTH(W), .MSB_FIRST(1'b0), .TIMEOUT(TO)) u_lsb (
    .clk(clk), .rst(rst), .start(start), .din(din), .ready(ready_l), .done(done_l),
    .err(err_l), .send(send_l), .data(data_l), .ack(ack_l));

  hs_sender #(.WIDTH(W), .MSB_FIRST(1'b1), .TIMEOUT(TO)) u_msb (
    .clk(clk), .rst(rst), .start(start), .din(din), .ready(ready_m), .done(done_m),
    .err(err_m), .send(send_m), .data(data_m), .ack(ack_m));

  // responder: sees send one cycle late, acks a cycle after, drops ack once send falls
  assign ack_l = force_ack | (resp_en & ra_l);
  assign ack_m = force_ack | (resp_en & ra_m);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_l <= 1'b0; ra_l <= 1'b0; r1_m <= 1'b0; ra_m <= 1'b0;
    end else begin
      r1_l <= send_l; ra_l <= r1_l & send_l;
      r1_m <= send_m; ra_m <= r1_m & send_m;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (r1_l && send_l && !ra_l) cap_l <= {cap_l[W-2:0], data_l};
    if (r1_m && send_m && !ra_m) cap_m <= {cap_m[W-2:0], data_m};
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0; t <= 0; m_err <= 1'b0;
    end else if (!active) begin
      if (start && !ack_l) begin
        active <= 1'b1; t <= 0; noack <= !resp_en; word <= din; m_err <= 1'b0;
        acc_cnt <= acc_cnt + 1;
      end
    end else begin
      if (noack && t == TO - 1) m_err <= 1'b1;
      if (t >= (noack ? TO : 5 * W)) active <= 1'b0;
      else t <= t + 1;
    end
  end

  function automatic logic exp_bit(input logic [W-1:0] w, input int i, input logic msb);
    return msb ? w[W-1-i] : w[i];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (time %0t)", name, act, req, $time);
    end
  endtask

  task automatic cmp_inst(input string tag, input logic s, input logic d, input logic r,
                          input logic dn, input logic e, input logic a, input logic prev_s,
                          input logic msb);
    logic es, ed, edn, ee, er, dchk;
    es = 1'b0; ed = 1'b0; edn = 1'b0; ee = m_err; er = !a; dchk = 1'b0;
    if (active) begin
      er = 1'b0; ee = 1'b0;
      if (!noack) begin
        if (t < 5 * W) begin
          es = ((t % 5) < 3); ed = exp_bit(word, t / 5, msb); dchk = 1'b1;
        end else edn = 1'b1;
      end else begin
        if (t < TO) begin
          es = 1'b1; ed = exp_bit(word, 0, msb); dchk = 1'b1;
        end else ee = 1'b1;
      end
    end
    chk({tag, ".send"}, 32'(s), 32'(es));
    chk({tag, ".done"}, 32'(dn), 32'(edn));
    chk({tag, ".err"}, 32'(e), 32'(ee));
    chk({tag, ".ready"}, 32'(r), 32'(er));
    if (dchk) chk({tag, ".data"}, 32'(d), 32'(ed));
    if (s && !prev_s) chk({tag, ".ack_at_send_rise"}, 32'(a), 0);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk); #2;
      if (!active && !ack_l) break;
    end
    if (k == 200) chk("idle_wait_expired", 0, 1);
  endtask

  task automatic start_xfer(input logic [W-1:0] w, input logic en, output int acc);
    wait_idle();
    din = w; resp_en = en; start = 1'b1; acc = cyc + 1;
    @(negedge clk); #2;
    start = 1'b0; din = W'($urandom);
    chk("accept_send", {30'd0, send_m, send_l}, 32'd3);
  endtask

  task automatic wait_done(input int acc, input string name);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (done_l) break;
    end
    chk({name, ".latency"}, cyc - acc, 5 * W);
    chk({name, ".done_m"}, 32'(done_m), 1);
    chk({name, ".ready_in_done"}, 32'(ready_l), 0);
  endtask

  initial begin
    fork
      begin : compare
        logic ps_l, ps_m;
        ps_l = 1'b0; ps_m = 1'b0;
        forever begin
          @(negedge clk);
          cmp_inst("lsb", send_l, data_l, ready_l, done_l, err_l, ack_l, ps_l, 1'b0);
          cmp_inst("msb", send_m, data_m, ready_m, done_m, err_m, ack_m, ps_m, 1'b1);
          ps_l = send_l; ps_m = send_m;
        end
      end
      begin : stim
        int acc0, n;
        repeat (2) @(negedge clk);
        #3 rst = 1'b0;
        @(negedge clk); #1;
        chk("rst.send", 32'(send_l), 0);
        chk("rst.data", 32'(data_l), 0);
        chk("rst.done", 32'(done_l), 0);
        chk("rst.err", 32'(err_l), 0);
        chk("rst.ready", 32'(ready_l), 1);
        chk("rst.data_m", 32'(data_m), 0);

        start_xfer(8'hA5, 1'b1, acc0);
        wait_done(acc0, "a5");
        chk("a5.cap_l", 32'(cap_l), 32'h000000A5);
        chk("a5.cap_m", 32'(cap_m), 32'h000000A5);

        start_xfer(8'h01, 1'b1, acc0);
        wait_done(acc0, "x01");
        chk("x01.cap_l", 32'(cap_l), 32'h00000080);
        chk("x01.cap_m", 32'(cap_m), 32'h00000001);

        start_xfer(8'h96, 1'b0, acc0);
        n = 1;
        for (int k = 0; k < 40; k++) begin
          @(negedge clk); #1;
          if (send_l) n++;
          else break;
        end
        chk("timeout.send_cycles", n, TO);
        chk("timeout.err", 32'(err_l), 1);
        repeat (5) @(negedge clk);
        #1;
        chk("timeout.err_sticky", {30'd0, err_m, err_l}, 32'd3);
        start_xfer(8'h3C, 1'b1, acc0);
        chk("x3c.err_cleared", 32'(err_l), 0);
        wait_done(acc0, "x3c");
        chk("x3c.cap_m", 32'(cap_m), 32'h0000003C);

        start_xfer(8'h5A, 1'b1, acc0);
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (t == 17) break;
        end
        #3 rst = 1'b1;
        #1;
        chk("midrst.send", {30'd0, send_m, send_l}, 0);
        chk("midrst.done", 32'(done_l), 0);
        @(posedge clk); #3 rst = 1'b0;
        n = 0;
        repeat (45) begin
          @(negedge clk); #1;
          if (done_l) n++;
        end
        chk("midrst.no_done", n, 0);
        start_xfer(8'hFF, 1'b1, acc0);
        wait_done(acc0, "xff");
        chk("xff.cap_l", 32'(cap_l), 32'h000000FF);

        wait_idle();
        n = acc_cnt; start = 1'b1; resp_en = 1'b1;
        repeat (126) @(posedge clk);
        @(negedge clk); #2;
        start = 1'b0;
        chk("held.accepts", acc_cnt - n, 3);

        wait_idle();
        n = acc_cnt; force_ack = 1'b1; start = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        chk("forced_ack.ready", {30'd0, ready_m, ready_l}, 0);
        #1;
        start = 1'b0; force_ack = 1'b0;
        chk("forced_ack.no_accept", acc_cnt - n, 0);

        for (int i = 0; i < 3000; i++) begin
          @(negedge clk); #2;
          start = ($urandom_range(0, 3) == 0);
          din   = W'($urandom);
          if (!active) begin
            resp_en   = ($urandom_range(0, 7) != 0);
            force_ack = ($urandom_range(0, 4) == 0);
          end else begin
            force_ack = 1'b0;
          end
          if ($urandom_range(0, 599) == 0) begin
            #1 rst = 1'b1;
            #1;
            chk("rand_rst.send", {30'd0, send_m, send_l}, 0);
            @(posedge clk); #3 rst = 1'b0;
          end
        end
        @(negedge clk); #2;
        start = 1'b0; force_ack = 1'b0;
        repeat (50) @(negedge clk);
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
